// File: rtl/regfile_dump_engine_if.sv
// Bus bundle for the register-file dump engine: one register-file read port
// plus the outgoing valid/ready byte stream.
interface regfile_dump_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;

    // Engine side: drives the read address and the stream.
    modport master (
        output rd_addr,
        input  rd_data,
        output out_byte,
        output out_valid,
        input  out_ready
    );

    // Register file and stream sink side.
    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_byte,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_engine.sv
// Register-file dump engine: on start, walks first_addr..last_addr (inclusive,
// wrapping) over one read port and emits each register as a 5-byte packet
// (header {3'b101, addr}, then data MSB first) on a valid/ready byte stream.
// Read-only towards the register file.
module regfile_dump_engine #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     first_addr,
    input  logic [ADDR_W-1:0]     last_addr,
    regfile_dump_engine_if.master bus,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } stateT;

    localparam int                 NUM_BYTES = DATA_W / 8;
    localparam int                 IDX_W     = $clog2(NUM_BYTES + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BYTES);
    localparam logic [ADDR_W:0]    REM_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]  TOP_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [2:0]         HDR_TAG   = 3'b101;

    stateT               stateQ;
    stateT               stateD;
    logic [ADDR_W-1:0]   curQ;          // register currently being dumped
    logic [ADDR_W:0]     remainingQ;    // registers left, including curQ
    logic [IDX_W-1:0]    byteIdxQ;      // 0 = header, 1..NUM_BYTES = data
    logic [DATA_W-1:0]   shadowQ;       // snapshot of the register taken in READ
    logic [ADDR_W-1:0]   rdAddrQ;       // last address presented, held outside READ
    logic [ADDR_W-1:0]   rangeSpan;
    logic                xfer;
    logic                lastByte;

    // Range length minus one; ADDR_W-bit subtraction gives the mod-NUM_REGS wrap.
    assign rangeSpan = last_addr - first_addr;
    assign xfer      = bus.out_valid && bus.out_ready;
    assign lastByte  = (byteIdxQ == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state decode plus control outputs; out_valid comes from state only.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        stateD        = stateQ;
        busy          = 1'b0;
        done          = 1'b0;
        bus.out_valid = 1'b0;
        bus.rd_addr   = rdAddrQ;
        case (stateQ)
            IDLE: begin
                if (start) begin
                    stateD = READ;
                end
            end
            READ: begin
                busy        = 1'b1;
                bus.rd_addr = curQ;
                stateD      = SEND;
            end
            SEND: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready && lastByte) begin
                    stateD = (remainingQ == REM_ONE) ? DONE : READ;
                end
            end
            DONE: begin
                done   = 1'b1;
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Stream byte select: header first, then shadow bytes MSB first.
    always_comb begin
        bus.out_byte = 8'h00;
        if (stateQ == SEND) begin
            if (byteIdxQ == '0) begin
                // Header carries the low five address bits under the 3'b101 tag.
                bus.out_byte = {HDR_TAG, 5'(curQ)};
            end else begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (byteIdxQ == IDX_W'(i + 1)) begin
                        bus.out_byte = shadowQ[DATA_W-1-8*i -: 8];
                    end
                end
            end
        end
    end

    // Datapath: range counters, byte index, shadow capture, held read address.
    always_ff @(posedge clk) begin
        if (reset) begin
            curQ       <= '0;
            remainingQ <= '0;
            byteIdxQ   <= '0;
            shadowQ    <= '0;
            rdAddrQ    <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        curQ       <= first_addr;
                        remainingQ <= (ADDR_W+1)'(rangeSpan) + REM_ONE;
                    end
                end
                READ: begin
                    // The file writes on this same edge, so rd_data here is
                    // still the pre-write value.
                    shadowQ  <= bus.rd_data;
                    byteIdxQ <= '0;
                    rdAddrQ  <= curQ;
                end
                SEND: begin
                    if (xfer) begin
                        if (lastByte) begin
                            if (remainingQ != REM_ONE) begin
                                curQ       <= (curQ == TOP_ADDR) ? '0 : curQ + ADDR_W'(1);
                                remainingQ <= remainingQ - REM_ONE;
                            end
                        end else begin
                            byteIdxQ <= byteIdxQ + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
